// File: rtl/rgb_arbiter.sv
// Fixed-priority RGB source arbiter: grants one of three colour sources and
// keeps the grant for a minimum number of enabled cycles before re-arbitrating.
module rgb_arbiter #(
  parameter int unsigned HOLD_CYCLES   = 4800000,
  parameter int unsigned CNT_W         = 26,
  parameter logic [23:0] DEFAULT_COLOR = 24'h000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [2:0]  req,
  input  logic [23:0] color0,
  input  logic [23:0] color1,
  input  logic [23:0] color2,
  output logic [2:0]  grant,
  output logic [23:0] out,
  output logic        busy
);

  localparam int unsigned COLOR_W = 24;
  localparam int unsigned REQ_W   = 3;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [REQ_W-1:0]   grant_q, grant_d;
  logic [COLOR_W-1:0] out_q, out_d;
  logic               busy_q, busy_d;
  logic [REQ_W-1:0]   pick_c;

  // Lowest-index request wins.
  always_comb begin
    pick_c = '0;
    if (req[0])      pick_c = 3'b001;
    else if (req[1]) pick_c = 3'b010;
    else if (req[2]) pick_c = 3'b100;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (req != '0) begin
          state_d = HOLD;
          grant_d = pick_c;
          cnt_d   = RELOAD;
        end else begin
          grant_d = '0;
        end
      end
      HOLD: begin
        if (en) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (req != '0) begin
            grant_d = pick_c;
            cnt_d   = RELOAD;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Output colour follows the grant that will be in effect after this edge.
  always_comb begin
    out_d  = DEFAULT_COLOR;
    busy_d = (grant_d != '0);
    case (grant_d)
      3'b001:  out_d = color0;
      3'b010:  out_d = color1;
      3'b100:  out_d = color2;
      default: out_d = DEFAULT_COLOR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      out_q   <= DEFAULT_COLOR;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
    end
  end

  assign grant = grant_q;
  assign out   = out_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_rgb_arbiter.sv
// Self-checking bench for rgb_arbiter: directed vector table, hand-written
// hold/reset sequences, and randomized traffic against a reference model.
module tb_rgb_arbiter;

  localparam int unsigned HOLD = 4;
  localparam logic [23:0] DEF  = 24'h000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic [2:0]  req = '0;
  logic [23:0] color0 = 24'hff0000;
  logic [23:0] color1 = 24'h00ff00;
  logic [23:0] color2 = 24'h0000ff;
  logic [2:0]  grant;
  logic [23:0] out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Reference model: index of granted source (-1 none) and enabled cycles shown.
  int          m_g = -1;
  int          m_shown = 0;
  logic [2:0]  m_grant;
  logic [23:0] m_out;

  rgb_arbiter #(
    .HOLD_CYCLES  (HOLD),
    .CNT_W        (8),
    .DEFAULT_COLOR(DEF)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .req   (req),
    .color0(color0),
    .color1(color1),
    .color2(color2),
    .grant (grant),
    .out   (out),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic [23:0] c0;
    logic [2:0]  g;
    logic        b;
    logic [23:0] o;
  } vec_t;

  function automatic int lowest(input logic [2:0] r);
    for (int i = 0; i < 3; i++) if (r[i]) return i;
    return -1;
  endfunction

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    if (rst) begin
      m_g = -1;
      m_shown = 0;
    end else if (m_g < 0) begin
      if (req != 3'b000) begin
        m_g = lowest(req);
        m_shown = 0;
      end
    end else if (en) begin
      m_shown++;
      if (m_shown >= HOLD) begin
        m_g = lowest(req);
        m_shown = 0;
      end
    end
    m_grant = (m_g < 0) ? 3'b000 : 3'(1 << m_g);
    case (m_g)
      0:       m_out = color0;
      1:       m_out = color1;
      2:       m_out = color2;
      default: m_out = DEF;
    endcase
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("model_grant", 24'(grant), 24'(m_grant));
    check("model_busy", 24'(busy), 24'(m_grant != 3'b000));
    check("model_out", out, m_out);
  endtask

  vec_t vecs[21];
  int   held;

  initial begin
    // Single request, blocked preemption, release, colour tracking.
    vecs[0]  = '{1'b1, 3'b000, 24'hff0000, 3'b000, 1'b0, 24'h000000};
    vecs[1]  = '{1'b0, 3'b010, 24'hff0000, 3'b010, 1'b1, 24'h00ff00};
    vecs[2]  = '{1'b0, 3'b010, 24'hff0000, 3'b010, 1'b1, 24'h00ff00};
    vecs[3]  = '{1'b0, 3'b010, 24'hff0000, 3'b010, 1'b1, 24'h00ff00};
    vecs[4]  = '{1'b0, 3'b010, 24'hff0000, 3'b010, 1'b1, 24'h00ff00};
    vecs[5]  = '{1'b0, 3'b010, 24'hff0000, 3'b010, 1'b1, 24'h00ff00};
    vecs[6]  = '{1'b0, 3'b100, 24'hff0000, 3'b010, 1'b1, 24'h00ff00};
    vecs[7]  = '{1'b0, 3'b100, 24'hff0000, 3'b010, 1'b1, 24'h00ff00};
    vecs[8]  = '{1'b0, 3'b100, 24'hff0000, 3'b010, 1'b1, 24'h00ff00};
    vecs[9]  = '{1'b0, 3'b100, 24'hff0000, 3'b100, 1'b1, 24'h0000ff};
    vecs[10] = '{1'b0, 3'b101, 24'hff0000, 3'b100, 1'b1, 24'h0000ff};
    vecs[11] = '{1'b0, 3'b101, 24'hff0000, 3'b100, 1'b1, 24'h0000ff};
    vecs[12] = '{1'b0, 3'b001, 24'hff0000, 3'b100, 1'b1, 24'h0000ff};
    vecs[13] = '{1'b0, 3'b001, 24'hff0000, 3'b001, 1'b1, 24'hff0000};
    vecs[14] = '{1'b0, 3'b000, 24'hff0000, 3'b001, 1'b1, 24'hff0000};
    vecs[15] = '{1'b0, 3'b000, 24'hff0000, 3'b001, 1'b1, 24'hff0000};
    vecs[16] = '{1'b0, 3'b000, 24'hff0000, 3'b001, 1'b1, 24'hff0000};
    vecs[17] = '{1'b0, 3'b000, 24'hff0000, 3'b000, 1'b0, 24'h000000};
    vecs[18] = '{1'b0, 3'b000, 24'hff0000, 3'b000, 1'b0, 24'h000000};
    vecs[19] = '{1'b0, 3'b001, 24'hff0000, 3'b001, 1'b1, 24'hff0000};
    vecs[20] = '{1'b0, 3'b001, 24'h0000ff, 3'b001, 1'b1, 24'h0000ff};

    for (int i = 0; i < 21; i++) begin
      rst    = vecs[i].rst;
      req    = vecs[i].req;
      color0 = vecs[i].c0;
      en     = 1'b1;
      step();
      check($sformatf("vec%0d_grant", i), 24'(grant), 24'(vecs[i].g));
      check($sformatf("vec%0d_busy", i), 24'(busy), 24'(vecs[i].b));
      check($sformatf("vec%0d_out", i), out, vecs[i].o);
    end

    // en low for 10 cycles mid-hold stretches the grant to 4 + 10 cycles.
    color0 = 24'hff0000;
    rst = 1'b1; req = 3'b000; step();
    rst = 1'b0; req = 3'b001; step();
    check("engate_first_grant", 24'(grant), 24'(3'b001));
    req = 3'b000;
    held = 1;
    for (int c = 0; c < 2; c++) begin step(); if (grant != 3'b000) held++; end
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin step(); if (grant != 3'b000) held++; end
    en = 1'b1;
    for (int c = 0; c < 20 && grant != 3'b000; c++) begin
      step();
      if (grant != 3'b000) held++;
    end
    check("engate_duration", 24'(held), 24'(HOLD + 10));
    check("engate_idle_after", 24'(grant), 24'(3'b000));

    // Reset pulse mid-hold with every source requesting.
    req = 3'b111; step(); step();
    check("rst_pre_grant", 24'(grant), 24'(3'b001));
    rst = 1'b1; step();
    check("rst_grant", 24'(grant), 24'(3'b000));
    check("rst_out", out, DEF);
    rst = 1'b0; step();
    check("rst_regrant", 24'(grant), 24'(3'b001));
    check("rst_regrant_out", out, color0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst    = ($urandom_range(0, 59) == 0);
      en     = ($urandom_range(0, 3) != 0);
      req    = ($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
      color0 = 24'($urandom);
      color1 = 24'($urandom);
      color2 = 24'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
